seq_branch_comp: RTL and testbench
==================================

Name: seq_branch_comp

Overview:
- Multi-cycle, parametrised successor to the single-cycle N-bit equality comparator, used by the branch unit of the RISC-V core.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
- Supports all six RV32I branch conditions (EQ, NE, LT, GE, LTU, GEU) selected by a funct3-style mode.
- Start/Busy/Done handshake, registered result. Trades latency for a narrow comparator datapath.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle, >=1. NCHUNK = WIDTH/CHUNK chunks.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Mode  input  3  condition, funct3 encoding: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal
- Data0  input  WIDTH  left operand (rs1), latched on accept
- Data1  input  WIDTH  right operand (rs2), latched on accept
- Busy  output  1  high while state != IDLE
- Done  output  1  one-cycle pulse; Out and Illegal valid
- Out  output  1  condition result, held until next accept
- Illegal  output  1  Mode was 010/011 on the accepted request; held like Out

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, Busy=0, Done=0, Out=0, Illegal=0, chunk index cleared. Reset has priority in every state, including mid-operation; the pending compare is discarded and no Done pulse is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Start=1 accepts the request: latch Data0, Data1 and Mode; idx=NCHUNK-1; go to BUSY.
  - Start=0: stay in IDLE.
- BUSY, each cycle: compare chunk idx of both latched operands.
  - Chunk NCHUNK-1 (MSB chunk) is compared signed for LT/GE and unsigned for LTU/GEU.
  - All lower chunks are compared unsigned.
  - The first differing chunk, MSB-first, fixes the ordering (less/greater). If all chunks are equal, the operands are equal.
  - Terminate when idx==0, or earlier per EARLY_EXIT_EN. On termination, register Out/Illegal and go to DONE. Otherwise decrement idx.
- DONE: Done=1 for exactly this one cycle, then go to IDLE.
- Busy=1 in BUSY and DONE. Start is ignored while Busy=1; no queuing. Start is accepted again on the first IDLE cycle.
- Result mapping:
  - EQ=equal; NE=!equal.
  - LT/LTU=less; GE/GEU=!less.
  - Illegal mode: Out=0, Illegal=1. Illegal mode still runs the normal number of cycles.
- Latency, start edge to Done cycle: NCHUNK+1 cycles when all chunks are evaluated. Throughput: one compare per NCHUNK+2 cycles.
- Operand inputs may change freely after accept; only latched copies are used.
- NCHUNK=1 is legal: one BUSY cycle.

Optional Feature:
- Macro EARLY_EXIT_EN.
- Defined: BUSY terminates on the first differing chunk, since the result is then decided. Latency becomes k+1, where k is the number of chunks evaluated (1..NCHUNK).
- Undefined: latency is always NCHUNK+1. A differing chunk is recorded in a sticky decided flag; later chunks cannot change the decision.
- Out/Illegal values are identical in both builds.

Test Plan (WIDTH=32, CHUNK=8):
- EQ, 32'h01234567 vs 32'h01234567 -> Busy 5 cycles, Done in the 5th cycle after accept edge, Out=1, Illegal=0. NE on same operands -> Out=0.
- LTU, 32'h01234567 vs 32'h01234568 -> Out=1. GEU same operands -> Out=0. 32'h01234567 vs 32'h01234566 LTU -> Out=0.
- LT, 32'h80000000 vs 32'h00000001 -> Out=1. LTU same operands -> Out=0. GE 32'h00000000 vs 32'hFFFFFFFF -> Out=1.
- EQ, 32'h01234567 vs 32'h76543210:
  - EARLY_EXIT_EN defined -> Done 2 cycles after accept, Out=0.
  - Not defined -> Done 5 cycles after accept, Out=0.
- Mode 3'b010 on 32'h0 vs 32'h0 -> Done, Out=0, Illegal=1. The next legal EQ request clears Illegal to 0.
- Accept EQ, then assert rst for one edge on the 2nd BUSY cycle -> Busy=0, Out=0, no Done pulse. Start pulses while Busy=1 must be ignored, checked by a Start held high through DONE being accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/seq_branch_comp.sv
// Chunk-serial RV32I branch comparator, MSB chunk first, start/busy/done handshake.
// Build option: define EARLY_EXIT_EN to finish on the first differing chunk.
module seq_branch_comp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] Data0,
    input  logic [WIDTH-1:0] Data1,
    output logic             Busy,
    output logic             Done,
    output logic             Out,
    output logic             Illegal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic [2:0]       mode_r;
    logic             decided;
    logic             less;
    logic             busy_r;
    logic             done_r;
    logic             out_r;
    logic             illegal_r;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             signed_cmp;
    logic             lt_now;
    logic             ne_now;
    logic             fin_less;
    logic             fin_eq;
    logic             finish;
    logic             res_out;
    logic             res_ill;

    // Operands shift left each cycle so the live chunk always sits at the top.
    assign ca = op0[WIDTH-1 -: CHUNK];
    assign cb = op1[WIDTH-1 -: CHUNK];

    assign signed_cmp = (idx == LAST) && !mode_r[1];
    assign ne_now     = (ca != cb);

    always_comb begin
        lt_now = 1'b0;
        if (signed_cmp)
            lt_now = ($signed(ca) < $signed(cb));
        else
            lt_now = (ca < cb);
    end

    assign fin_less = decided ? less : (ne_now && lt_now);
    assign fin_eq   = !(decided || ne_now);

`ifdef EARLY_EXIT_EN
    assign finish = (idx == '0) || ne_now;
`else
    assign finish = (idx == '0);
`endif

    always_comb begin
        res_out = 1'b0;
        res_ill = 1'b0;
        unique case (mode_r)
            3'b000: res_out = fin_eq;
            3'b001: res_out = !fin_eq;
            3'b100: res_out = fin_less;
            3'b110: res_out = fin_less;
            3'b101: res_out = !fin_less;
            3'b111: res_out = !fin_less;
            default: res_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            op0       <= '0;
            op1       <= '0;
            mode_r    <= '0;
            decided   <= 1'b0;
            less      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            out_r     <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        op0     <= Data0;
                        op1     <= Data1;
                        mode_r  <= Mode;
                        idx     <= LAST;
                        decided <= 1'b0;
                        less    <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        out_r     <= res_out;
                        illegal_r <= res_ill;
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        op0 <= op0 << CHUNK;
                        op1 <= op1 << CHUNK;
                        // First difference wins; later chunks cannot override it.
                        if (!decided && ne_now) begin
                            decided <= 1'b1;
                            less    <= lt_now;
                        end
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Out     = out_r;
    assign Illegal = illegal_r;

endmodule

// File: tb/tb_seq_branch_comp.sv
// Self-checking bench for seq_branch_comp: directed cases plus random
// compares against an arithmetic reference model.
module tb_seq_branch_comp;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [2:0]  Mode;
    logic [31:0] Data0;
    logic [31:0] Data1;
    logic        Busy;
    logic        Done;
    logic        Out;
    logic        Illegal;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] M_EQ  = 3'b000;
    localparam logic [2:0] M_NE  = 3'b001;
    localparam logic [2:0] M_LT  = 3'b100;
    localparam logic [2:0] M_GE  = 3'b101;
    localparam logic [2:0] M_LTU = 3'b110;
    localparam logic [2:0] M_GEU = 3'b111;

    seq_branch_comp #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk),
        .rst(rst),
        .Start(Start),
        .Mode(Mode),
        .Data0(Data0),
        .Data1(Data1),
        .Busy(Busy),
        .Done(Done),
        .Out(Out),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_out(input logic [2:0] m, input logic [31:0] a,
                                       input logic [31:0] b);
        case (m)
            M_EQ:    return a == b;
            M_NE:    return a != b;
            M_LT:    return $signed(a) < $signed(b);
            M_GE:    return !($signed(a) < $signed(b));
            M_LTU:   return a < b;
            M_GEU:   return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_ill(input logic [2:0] m);
        return (m == 3'b010) || (m == 3'b011);
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef EARLY_EXIT_EN
        for (int k = 1; k <= 4; k++)
            if (a[(4-k)*8 +: 8] != b[(4-k)*8 +: 8])
                return k + 1;
`else
        if (a == b) return 5;
`endif
        return 5;
    endfunction

    // Called #1 after the accept edge; counts cycles until Done (cycle 1 = first after accept).
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 1;
        busy_n = (Busy === 1'b1) ? 1 : 0;
        while (Done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (Busy === 1'b1) busy_n++;
        end
    endtask

    task automatic do_op(input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int cyc;
        int busy_n;
        @(negedge clk);
        Start = 1'b1;
        Mode  = m;
        Data0 = a;
        Data1 = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Data0 = $urandom;
        Data1 = $urandom;
        Mode  = 3'($urandom);
        wait_done(cyc, busy_n);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(model_lat(a, b)));
        chk({tag, "_busyn"}, 32'(busy_n), 32'(model_lat(a, b)));
        chk({tag, "_out"}, 32'(Out), 32'(model_out(m, a, b)));
        chk({tag, "_ill"}, 32'(Illegal), 32'(model_ill(m)));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {30'd0, Busy, Done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int busy_n;
        int pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  m;

        rst   = 1'b1;
        Start = 1'b0;
        Mode  = 3'b000;
        Data0 = 32'h0;
        Data1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, Busy, Done, Out, Illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(M_EQ,  32'h01234567, 32'h01234567, "eq_same");
        do_op(M_NE,  32'h01234567, 32'h01234567, "ne_same");
        do_op(M_LTU, 32'h01234567, 32'h01234568, "ltu_lsb");
        do_op(M_GEU, 32'h01234567, 32'h01234568, "geu_lsb");
        do_op(M_LTU, 32'h01234567, 32'h01234566, "ltu_gt");
        do_op(M_LT,  32'h80000000, 32'h00000001, "lt_neg");
        do_op(M_LTU, 32'h80000000, 32'h00000001, "ltu_big");
        do_op(M_GE,  32'h00000000, 32'hFFFFFFFF, "ge_m1");
        do_op(M_EQ,  32'h01234567, 32'h76543210, "eq_msbdiff");
        do_op(M_LT,  32'h7F00FF00, 32'h7F010000, "lt_midchunk");
        do_op(3'b010, 32'h0, 32'h0, "illegal2");
        do_op(M_EQ,  32'h0, 32'h0, "eq_after_ill");
        do_op(3'b011, 32'h5, 32'h5, "illegal3");

        // Reset on the 2nd BUSY cycle discards the compare.
        do_op(M_EQ, 32'hCAFE0001, 32'hCAFE0001, "pre_rst");
        @(negedge clk);
        Start = 1'b1;
        Mode  = M_EQ;
        Data0 = 32'h11111111;
        Data1 = 32'h22222222;
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid", {28'd0, Busy, Done, Out, Illegal}, 32'd0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1 || Busy === 1'b1) pulses++;
        end
        chk("rst_no_done", 32'(pulses), 32'd0);

        // Start held high: second request only taken in the first IDLE cycle.
        @(negedge clk);
        Start = 1'b1;
        Mode  = M_EQ;
        Data0 = 32'hA5A5A5A5;
        Data1 = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        Data1 = 32'hA5A5A5A4;
        wait_done(cyc, busy_n);
        chk("hold_done", 32'(Done), 32'd1);
        chk("hold_out1", 32'(Out), 32'd1);
        chk("hold_busy_done", 32'(Busy), 32'd1);
        @(posedge clk);
        #1;
        chk("hold_idle", {30'd0, Busy, Done}, 32'd0);
        @(posedge clk);
        #1;
        chk("hold_accept", 32'(Busy), 32'd1);
        @(negedge clk);
        Start = 1'b0;
        wait_done(cyc, busy_n);
        chk("hold2_lat", 32'(cyc), 32'(model_lat(32'hA5A5A5A5, 32'hA5A5A5A4)));
        chk("hold2_out", 32'(Out), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom;
                2: b = a ^ (32'(8'($urandom_range(1, 255))) << (8 * $urandom_range(0, 3)));
                default: b = {~a[31], a[30:0]} ^ 32'(8'($urandom));
            endcase
            m = 3'($urandom);
            do_op(m, a, b, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
